// File: rtl/wr_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wr_port_arbiter_if
// Bundles the requester side and the memory write-stage side of the shared
// write port arbiter. The requester fabric uses the master modport, the
// arbiter itself uses the slave modport.
// Optional macro: WR_ARB_LOCK_EN adds the per-requester i_lock vector.
// ---------------------------------------------------------------------------
interface wr_port_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           i_req;
    logic [NUM_REQ*SIZE_ADDR-1:0] i_addr;
    logic [NUM_REQ*SIZE_DATA-1:0] i_data;
    logic                         i_hold;
`ifdef WR_ARB_LOCK_EN
    logic [NUM_REQ-1:0]           i_lock;
`endif
    logic                         o_wr_en;
    logic [SIZE_ADDR-1:0]         o_addr_wr;
    logic [SIZE_DATA-1:0]         o_data_wr;
    logic [NUM_REQ-1:0]           o_ack;
    logic [IDW-1:0]               o_grant_id;
    logic                         o_busy;

    // Requester side: drives requests, observes grants and the write stage
    modport master (
`ifdef WR_ARB_LOCK_EN
        output i_lock,
`endif
        output i_req,
        output i_addr,
        output i_data,
        output i_hold,
        input  o_wr_en,
        input  o_addr_wr,
        input  o_data_wr,
        input  o_ack,
        input  o_grant_id,
        input  o_busy
    );

    // Arbiter side: consumes requests, drives the write stage and acks
    modport slave (
`ifdef WR_ARB_LOCK_EN
        input  i_lock,
`endif
        input  i_req,
        input  i_addr,
        input  i_data,
        input  i_hold,
        output o_wr_en,
        output o_addr_wr,
        output o_data_wr,
        output o_ack,
        output o_grant_id,
        output o_busy
    );
endinterface

// File: rtl/wr_port_arbiter.sv
// ---------------------------------------------------------------------------
// wr_port_arbiter
// Round-robin arbiter sharing one memory write port between NUM_REQ
// requesters. The winner's address/data are registered into the write stage
// together with a one-cycle one-hot ack, one write per cycle at most.
// The requester acked in the current cycle is masked so a level-held request
// that has just been served cannot be granted twice.
// Optional macro: WR_ARB_LOCK_EN lets the last winner keep the port for up
// to MAX_LOCK consecutive grants while it holds its i_lock bit.
// ---------------------------------------------------------------------------
module wr_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8,
    parameter int MAX_LOCK  = 4
) (
    input logic             i_clk,
    input logic             i_rst_n,
    wr_port_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    typedef logic [IDW-1:0] id_t;
    localparam id_t LAST_ID = id_t'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    // Reject illegal configurations at elaboration time
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LOCK < 1 || MAX_LOCK > 15 ||
        SIZE_ADDR < 1 || SIZE_DATA < 1) begin : g_bad_params
        $error("wr_port_arbiter: illegal parameter combination");
    end

    // Registered write stage, ack and round-robin state
    logic                 wrEn_q,    wrEn_d;
    logic [SIZE_ADDR-1:0] addrWr_q,  addrWr_d;
    logic [SIZE_DATA-1:0] dataWr_q,  dataWr_d;
    logic [NUM_REQ-1:0]   ack_q,     ack_d;
    id_t                  grantId_q, grantId_d;
    id_t                  rrPtr_q,   rrPtr_d;

    // Combinational arbitration results
    logic [NUM_REQ-1:0]   eligible;
    logic                 lockWin;
    logic                 found;
    id_t                  winner;
    logic                 grantValid;
    id_t                  grantSel;

`ifdef WR_ARB_LOCK_EN
    localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK - 1);
    logic [3:0]           lockCnt_q, lockCnt_d;
`endif

    // Build the eligible set and decide whether the last winner keeps the lock
    always_comb begin
        eligible = bus.i_req & ~ack_q;
        lockWin  = 1'b0;
`ifdef WR_ARB_LOCK_EN
        lockWin  = wrEn_q && bus.i_lock[grantId_q] && bus.i_req[grantId_q] &&
                   (lockCnt_q < LOCK_LIMIT);
`endif
    end

    // Search upward from the pointer with wrap for the first eligible index
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rrPtr_q) + i) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = id_t'(idx);
            end
        end
    end

    // A locked winner overrides the round-robin choice; hold blocks all grants
    always_comb begin
        grantSel   = lockWin ? grantId_q : winner;
        grantValid = !bus.i_hold && (lockWin || found);
    end

    // Next-state for the write stage, ack and pointer
    always_comb begin
        wrEn_d    = 1'b0;
        ack_d     = '0;
        addrWr_d  = addrWr_q;
        dataWr_d  = dataWr_q;
        grantId_d = grantId_q;
        rrPtr_d   = rrPtr_q;
        if (grantValid) begin
            wrEn_d    = 1'b1;
            ack_d     = ONE_HOT0 << grantSel;
            addrWr_d  = bus.i_addr[int'(grantSel)*SIZE_ADDR +: SIZE_ADDR];
            dataWr_d  = bus.i_data[int'(grantSel)*SIZE_DATA +: SIZE_DATA];
            grantId_d = grantSel;
            if (!lockWin) begin
                rrPtr_d = (grantSel == LAST_ID) ? id_t'(0) : id_t'(grantSel + 1'b1);
            end
        end
    end

`ifdef WR_ARB_LOCK_EN
    // Lock counter: count repeat wins, clear on a normal grant or dropped lock
    always_comb begin
        lockCnt_d = lockCnt_q;
        if (!bus.i_hold) begin
            if (lockWin) begin
                lockCnt_d = 4'(lockCnt_q + 4'd1);
            end else if (grantValid) begin
                lockCnt_d = '0;
            end else if (!bus.i_lock[grantId_q]) begin
                lockCnt_d = '0;
            end
        end
    end

    // Lock counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lockCnt_q <= '0;
        end else begin
            lockCnt_q <= lockCnt_d;
        end
    end
`endif

    // Arbiter state registers, cleared immediately by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrEn_q    <= 1'b0;
            ack_q     <= '0;
            addrWr_q  <= '0;
            dataWr_q  <= '0;
            grantId_q <= '0;
            rrPtr_q   <= '0;
        end else begin
            wrEn_q    <= wrEn_d;
            ack_q     <= ack_d;
            addrWr_q  <= addrWr_d;
            dataWr_q  <= dataWr_d;
            grantId_q <= grantId_d;
            rrPtr_q   <= rrPtr_d;
        end
    end

    // Drive the write stage and status outputs
    always_comb begin
        bus.o_wr_en    = wrEn_q;
        bus.o_addr_wr  = addrWr_q;
        bus.o_data_wr  = dataWr_q;
        bus.o_ack      = ack_q;
        bus.o_grant_id = grantId_q;
        bus.o_busy     = |bus.i_req;
    end

endmodule
